// File: rtl/rr_arbiter_16_pkg.sv
// rr_arbiter_16_pkg
//   Shared constants and state encoding for the 16-way round-robin arbiter.
//   N_REQ   : number of requesters (16)
//   IDX_W   : width of a requester index (4)
//   HOLD_W  : width of the GRANT-cycle counter (8)
//   state_t : arbiter FSM states; 2'd3 is unused and recovers to IDLE.
package rr_arbiter_16_pkg;

  localparam int N_REQ  = 16;
  localparam int IDX_W  = 4;
  localparam int HOLD_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/decoder_4x16.sv
// decoder_4x16
//   4-to-16 decoder with active-low enable and active-low one-hot outputs.
//   E : active-low enable (1 forces every output high)
//   A : 4-bit select index
//   D : active-low outputs, D[i]=0 iff E=0 and A=i (D[0] is the MSB)
module decoder_4x16 (
  input  logic       E,
  input  logic [3:0] A,
  output logic [0:15] D
);

  for (genvar gi = 0; gi < 16; gi++) begin : g_out
    assign D[gi] = E | (A != 4'(gi));
  end

endmodule

// File: rtl/rr_arbiter_16.sv
// rr_arbiter_16
//   Round-robin arbiter for 16 requesters driving a 4-to-16 active-low
//   decoder. Grants are held until the owner releases (done, or dropping
//   its request) or MAX_HOLD cycles elapse, followed by a one-cycle gap
//   with the enable deasserted before the next owner is chosen.
//   clk     : system clock, rising edge
//   rst     : asynchronous active-high reset
//   req     : active-high requests, req[i] belongs to requester i
//   done    : release strobe from the current owner
//   A       : registered winner index
//   E       : registered active-low grant enable
//   D       : active-low one-hot grant from the decoder
//   busy    : high while in GRANT or GAP
//   timeout : one-cycle pulse (during GAP) when a grant was revoked by MAX_HOLD
module rr_arbiter_16
  import rr_arbiter_16_pkg::*;
#(
  parameter int MAX_HOLD = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [0:N_REQ-1] req,
  input  logic             done,
  output logic [IDX_W-1:0] A,
  output logic             E,
  output logic [0:N_REQ-1] D,
  output logic             busy,
  output logic             timeout
);

  // Value of hold_cnt during the last permitted GRANT cycle.
  localparam logic [HOLD_W-1:0] HOLD_LAST =
    (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);
  localparam bit HOLD_EN = (MAX_HOLD != 0);

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   a_reg, a_next;
  logic               e_reg, e_next;
  logic [IDX_W-1:0]   ptr_reg, ptr_next;
  logic [HOLD_W-1:0]  hold_cnt_reg, hold_cnt_next;
  logic               timeout_reg, timeout_next;

  logic [IDX_W-1:0]   winner;
  logic               any_req;
  logic               limit_hit;
  logic               owner_release;

  // First requester at or after ptr, wrapping modulo 16. Falls back to ptr
  // when nothing is requesting; the result is unused in that case.
  function automatic logic [IDX_W-1:0] rr_pick(
    input logic [0:N_REQ-1] r,
    input logic [IDX_W-1:0] p
  );
    logic             found;
    logic [IDX_W-1:0] idx;
    rr_pick = p;
    found   = 1'b0;
    for (int off = 0; off < N_REQ; off++) begin
      idx = p + off[IDX_W-1:0];
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  assign winner        = rr_pick(req, ptr_reg);
  assign any_req       = |req;
  assign limit_hit     = HOLD_EN && (hold_cnt_reg == HOLD_LAST);
  assign owner_release = done || !req[a_reg];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      a_reg        <= '0;
      e_reg        <= 1'b1;
      ptr_reg      <= '0;
      hold_cnt_reg <= '0;
      timeout_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      a_reg        <= a_next;
      e_reg        <= e_next;
      ptr_reg      <= ptr_next;
      hold_cnt_reg <= hold_cnt_next;
      timeout_reg  <= timeout_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    a_next        = a_reg;
    e_next        = e_reg;
    ptr_next      = ptr_reg;
    hold_cnt_next = hold_cnt_reg;
    timeout_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        e_next = 1'b1;
        if (any_req) begin
          state_next    = GRANT;
          a_next        = winner;
          e_next        = 1'b0;
          hold_cnt_next = '0;
        end
      end

      GRANT: begin
        hold_cnt_next = (hold_cnt_reg == '1) ? hold_cnt_reg
                                             : hold_cnt_reg + HOLD_W'(1);
        if (owner_release || limit_hit) begin
          state_next   = GAP;
          e_next       = 1'b1;
          ptr_next     = a_reg + IDX_W'(1);
          // A coincident owner release counts as a normal release.
          timeout_next = limit_hit && !owner_release;
        end
      end

      GAP: begin
        state_next = IDLE;
        e_next     = 1'b1;
      end

      default: begin
        state_next = IDLE;
        e_next     = 1'b1;
      end
    endcase
  end

  assign A       = a_reg;
  assign E       = e_reg;
  assign busy    = (state_reg == GRANT) || (state_reg == GAP);
  assign timeout = timeout_reg;

  decoder_4x16 u_dec (
    .E (e_reg),
    .A (a_reg),
    .D (D)
  );

endmodule
